edge_frame_writer: RTL and testbench
====================================

Name: edge_frame_writer

Overview:
- Sink for the 3x3 edge-filter output stream: accepts signed 12-bit filtered pixels (`pix_valid`/`pix_data`) and regenerates raster coordinates.
- Converts each pixel to scaled unsigned magnitude and writes it to frame memory via a valid/ready write port with linear address.
- Absorbs memory backpressure in a small FWFT FIFO. Signals end of frame and sticky overflow.
- Sits between the convolution block and the SDRAM/VGA frame-buffer writer.

Parameters:
- WIDTH, 1280, pixels per line.
- HEIGHT, 960, lines per frame.
- ADDR_W, 21, write address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- GAIN_SHIFT, 0, left shift (0..3) applied to magnitude before saturation.
- FIFO_DEPTH, 16, output FIFO entries; power of two, >= 4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; arms capture of next frame.
- pix_valid  in  1  filtered pixel valid; no backpressure upstream.
- pix_data  in  12  signed two's-complement filtered pixel.
- wr_valid  out  1  write request to frame memory.
- wr_ready  in  1  frame memory accepts write when wr_valid & wr_ready.
- wr_addr  out  ADDR_W  linear address y*WIDTH+x.
- wr_data  out  12  unsigned gray magnitude.
- busy  out  1  high in STREAM or DRAIN.
- frame_done  out  1  one-cycle pulse after last write accepted.
- overflow  out  1  sticky: a pixel was dropped because FIFO was full.

Behaviour:
- Clock/reset: one clock `clk`; reset `rst_n` is asynchronous, active-low. All state clears on reset, including mid-frame: state=IDLE, x=y=0, FIFO empty, stage register invalid, all outputs 0. A write in flight is abandoned.
- States:
  - IDLE: pix_valid ignored. start -> STREAM; start also clears overflow, x, y.
  - STREAM: each pix_valid is one pixel at (x,y).
    - x increments and wraps at WIDTH-1 to 0, incrementing y.
    - The pixel at (WIDTH-1,HEIGHT-1) is the last. Accepting it -> DRAIN.
  - DRAIN: pix_valid ignored. When FIFO empty and stage register empty and no write pending -> DONE.
  - DONE: frame_done=1 for exactly one cycle -> IDLE.
  - start in any state other than IDLE is ignored.
- Arithmetic (stage 1, registered):
  - mag = |pix_data| as 12-bit unsigned; -2048 -> 2048, no overflow.
  - scaled = mag << GAIN_SHIFT, saturated to 4095.
  - addr computed by running counter, incremented by 1 per accepted pixel; no multiplier. Resets to 0 on start.
- Stage 2: {addr, scaled} pushed into FWFT FIFO the cycle after stage 1 loads.
- Latency: pix_valid in cycle N with FIFO empty and wr_ready=1 -> wr_valid=1 with that pixel's data in cycle N+2. Throughput is 1 pixel/cycle while wr_ready=1.
- Write port rules:
  - wr_valid/wr_addr/wr_data come from the FIFO head.
  - They are held stable while wr_valid & !wr_ready.
  - Pop on wr_valid & wr_ready.
- Full FIFO: push with FIFO full and no simultaneous pop -> entry dropped, overflow set (sticky until next start). Counters still advance, so later pixels keep correct addresses.
- Simultaneous push and pop when full -> both occur, no drop.
- Empty FIFO: wr_valid=0; wr_addr/wr_data are don't-care.
- busy=1 in STREAM and DRAIN only.

Decomposition:
- Package edge_writer_pkg: state enum (IDLE, STREAM, DRAIN, DONE) as 2-bit typedef; localparam PIX_W=12; function sat_shift(mag, shift).
- Sub-module pix_fwft_fifo:
  - Parameters DEPTH and DATA_WIDTH = ADDR_W+12.
  - Ports: push, pop, din, dout, full, empty, count.
  - dout valid combinationally when !empty.
- Top holds FSM, counters, stage registers, overflow.

Test Plan:
1. WIDTH=4, HEIGHT=2, GAIN_SHIFT=0, wr_ready=1. start, then 8 back-to-back pixels {0,1,-1,2047,-2048,5,-5,100} -> writes addr 0..7, data {0,1,1,2047,2048,5,5,100}. First wr_valid 2 cycles after first pix_valid. frame_done pulses once after addr 7 is accepted; busy falls the same cycle frame_done rises.
2. GAIN_SHIFT=2, pixels {-1000,1023,1024} -> data {4000,4092,4095}; the last value is saturated.
3. wr_ready=0 throughout 8 pixels, FIFO_DEPTH=4 -> 4 entries held with addr 0 stable on the port, overflow=1. Release wr_ready -> addrs 0,1,2,3 written (stage-register pixel 4 dropped per full rule, check consistently), frame_done pulses.
4. Toggle wr_ready 1/0 each cycle with continuous pixels, FIFO_DEPTH=16 -> all 8 addresses written exactly once, in order, overflow=0.
5. pix_valid pulses before start and during DRAIN -> no writes. start asserted during STREAM -> ignored; frame count stays 8.
6. Assert rst_n=0 after 3 pixels with writes pending -> all outputs 0 immediately. A fresh start after release writes from addr 0 with overflow=0.

Source files
------------

// File: rtl/edge_frame_writer_pkg.sv
// Shared types and pixel arithmetic for the edge-filter frame writer.
// Holds the FSM state encoding, the pixel width and the magnitude/gain helpers.
package edge_writer_pkg;

    localparam int PIX_W = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Two's-complement negation in 12 bits maps -2048 onto 0x800, which is 2048 unsigned.
    function automatic logic [PIX_W-1:0] abs_mag(input logic [PIX_W-1:0] v);
        logic [PIX_W-1:0] neg;
        neg = ~v + {{(PIX_W-1){1'b0}}, 1'b1};
        return v[PIX_W-1] ? neg : v;
    endfunction

    function automatic logic [PIX_W-1:0] sat_shift(input logic [PIX_W-1:0] mag,
                                                    input logic [1:0]       shift);
        logic [PIX_W+2:0] wide;
        wide = {3'b000, mag} << shift;
        if (|wide[PIX_W+2:PIX_W]) begin
            return {PIX_W{1'b1}};
        end
        return wide[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/edge_frame_writer_fifo.sv
// First-word-fall-through FIFO holding {address, magnitude} write entries.
// The head entry is visible on dout whenever the FIFO is not empty.
module pix_fwft_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 33
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_WIDTH-1:0]     din,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         rd_ptr_q;
    logic [PW-1:0]         wr_ptr_q;
    logic [PW:0]           count_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/edge_frame_writer.sv
// Frame sink for the edge filter: rebuilds raster position, converts pixels to
// saturated magnitudes and queues linear-address writes toward frame memory.
module edge_frame_writer
    import edge_writer_pkg::*;
#(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 960,
    parameter int ADDR_W     = 21,
    parameter int GAIN_SHIFT = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [11:0]       pix_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int FW = ADDR_W + PIX_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ovf_q, ovf_d;

    logic              s1_vld_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [PIX_W-1:0]  s1_data_q;

    logic              pix_acc;
    logic              last_pix;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;
    logic [FW-1:0]     fifo_dout;
    logic [CW-1:0]     fifo_count;

    assign pix_acc  = (state_q == STREAM) && pix_valid;
    assign last_pix = pix_acc && (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));
    assign fifo_pop = !fifo_empty && wr_ready;
    assign drop     = s1_vld_q && fifo_full && !fifo_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = STREAM;
            STREAM:  if (last_pix) state_d = DRAIN;
            DRAIN:   if ((fifo_count == '0) && !s1_vld_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == STREAM) || (state_q == DRAIN);
        frame_done = (state_q == DONE);
    end

    // The linear address is a running count, so y*WIDTH+x never needs a multiplier.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        ovf_d  = ovf_q;
        if ((state_q == IDLE) && start) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (pix_acc) begin
                addr_d = addr_q + ADDR_W'(1);
                if (x_q == XW'(WIDTH - 1)) begin
                    x_d = '0;
                    y_d = y_q + YW'(1);
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            addr_q   <= '0;
            ovf_q    <= 1'b0;
            s1_vld_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            addr_q   <= addr_d;
            ovf_q    <= ovf_d;
            s1_vld_q <= pix_acc;
        end
    end

    // Stage 1: magnitude, gain and saturation registered alongside the pixel address.
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            s1_addr_q <= addr_q;
            s1_data_q <= sat_shift(abs_mag(pix_data), 2'(GAIN_SHIFT));
        end
    end

    // Stage 2: the registered entry enters the FIFO one cycle after stage 1 loads.
    pix_fwft_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .DATA_WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s1_vld_q),
        .pop   (fifo_pop),
        .din   ({s1_addr_q, s1_data_q}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign wr_valid = !fifo_empty;
    assign wr_addr  = fifo_empty ? '0 : fifo_dout[FW-1:PIX_W];
    assign wr_data  = fifo_empty ? '0 : fifo_dout[PIX_W-1:0];
    assign overflow = ovf_q;

endmodule

// File: tb/tb_edge_frame_writer.sv
// Bench for edge_frame_writer: two instances (shallow/no-gain and deep/gain-2)
// checked every cycle against a queue-level reference of the write stream.
module tb_edge_frame_writer;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int AW   = 5;
    localparam int NPIX = W * H;
    localparam int DW   = AW + 12;

    typedef logic [DW-1:0] ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start     [2];
    logic          pix_valid [2];
    logic [11:0]   pix_data  [2];
    logic          wr_ready  [2];
    logic          wr_valid  [2];
    logic [AW-1:0] wr_addr   [2];
    logic [11:0]   wr_data   [2];
    logic          busy      [2];
    logic          frame_done[2];
    logic          overflow  [2];

    int checks   = 0;
    int failures = 0;

    // Reference state: write queue, pending stage entry, frame phase, pixel count, sticky drop flag.
    ent_t        mq      [2][$];
    ent_t        obs     [2][$];
    logic        m_svld  [2];
    ent_t        m_sval  [2];
    int          m_phase [2];
    int          m_cnt   [2];
    logic        m_ovf   [2];
    logic [11:0] fpix    [2][NPIX];

    always #5 clk = ~clk;

    edge_frame_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .GAIN_SHIFT(0), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .pix_valid(pix_valid[0]), .pix_data(pix_data[0]),
        .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .busy(busy[0]), .frame_done(frame_done[0]), .overflow(overflow[0]));

    edge_frame_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .GAIN_SHIFT(2), .FIFO_DEPTH(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .pix_valid(pix_valid[1]), .pix_data(pix_data[1]),
        .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .busy(busy[1]), .frame_done(frame_done[1]), .overflow(overflow[1]));

    function automatic int gain_of(int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic int depth_of(int d);
        return (d == 0) ? 4 : 16;
    endfunction

    function automatic int exp_data(logic [11:0] pd, int g);
        int v;
        v = int'($signed(pd));
        if (v < 0) v = -v;
        v = v << g;
        return (v > 4095) ? 4095 : v;
    endfunction

    task automatic check(string tag, int d, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, got, exp);
        end
    endtask

    task automatic mreset();
        for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            obs[d].delete();
            m_svld[d]  = 1'b0;
            m_sval[d]  = '0;
            m_phase[d] = 0;
            m_cnt[d]   = 0;
            m_ovf[d]   = 1'b0;
        end
    endtask

    task automatic mstep(int d);
        logic pop;
        logic full;
        logic drained;
        logic nsv;
        pop     = (mq[d].size() > 0) && wr_ready[d];
        full    = (mq[d].size() == depth_of(d));
        drained = (mq[d].size() == 0) && !m_svld[d];
        if (pop) void'(mq[d].pop_front());
        if (m_svld[d]) begin
            if (!full || pop) mq[d].push_back(m_sval[d]);
            else m_ovf[d] = 1'b1;
        end
        nsv = (m_phase[d] == 1) && pix_valid[d];
        if (nsv) m_sval[d] = {AW'(m_cnt[d]), 12'(exp_data(pix_data[d], gain_of(d)))};
        m_svld[d] = nsv;
        case (m_phase[d])
            0: if (start[d]) begin m_phase[d] = 1; m_cnt[d] = 0; m_ovf[d] = 1'b0; end
            1: if (pix_valid[d]) begin
                   m_cnt[d]++;
                   if (m_cnt[d] == NPIX) m_phase[d] = 2;
               end
            2: if (drained) m_phase[d] = 3;
            default: m_phase[d] = 0;
        endcase
    endtask

    task automatic compare(int d);
        ent_t h;
        check("wr_valid", d, 32'(wr_valid[d]), 32'(mq[d].size() > 0));
        if (mq[d].size() > 0) begin
            h = mq[d][0];
            check("wr_addr", d, 32'(wr_addr[d]), 32'(h[DW-1:12]));
            check("wr_data", d, 32'(wr_data[d]), 32'(h[11:0]));
        end
        check("busy", d, 32'(busy[d]), 32'((m_phase[d] == 1) || (m_phase[d] == 2)));
        check("frame_done", d, 32'(frame_done[d]), 32'(m_phase[d] == 3));
        check("overflow", d, 32'(overflow[d]), 32'(m_ovf[d]));
    endtask

    task automatic cyc();
        for (int d = 0; d < 2; d++)
            if (wr_valid[d] && wr_ready[d]) obs[d].push_back({wr_addr[d], wr_data[d]});
        @(posedge clk);
        for (int d = 0; d < 2; d++) mstep(d);
        #1;
        for (int d = 0; d < 2; d++) compare(d);
    endtask

    function automatic logic next_rdy(int mode, int pct, logic cur);
        if (mode == 1) return !cur;
        if (mode == 2) return ($urandom_range(0, 99) < pct);
        return cur;
    endfunction

    task automatic wait_done(int d, int budget, int mode, int pct);
        int n;
        n = 0;
        while (!frame_done[d] && n < budget) begin
            wr_ready[d] = next_rdy(mode, pct, wr_ready[d]);
            cyc();
            n++;
        end
        check("frame_done_seen", d, 32'(frame_done[d]), 32'(1));
        check("busy_low_at_done", d, 32'(busy[d]), 32'(0));
        cyc();
    endtask

    task automatic run_frame(int d, int mode, int pct, int maxgap);
        int gaps;
        obs[d].delete();
        start[d] = 1'b1;
        cyc();
        start[d] = 1'b0;
        for (int k = 0; k < NPIX; k++) begin
            gaps = $urandom_range(0, maxgap);
            for (int g = 0; g < gaps; g++) begin
                pix_valid[d] = 1'b0;
                wr_ready[d]  = next_rdy(mode, pct, wr_ready[d]);
                cyc();
            end
            pix_valid[d] = 1'b1;
            pix_data[d]  = fpix[d][k];
            wr_ready[d]  = next_rdy(mode, pct, wr_ready[d]);
            cyc();
        end
        pix_valid[d] = 1'b0;
        wait_done(d, 200, mode, pct);
    endtask

    task automatic check_in_order(int d, string tag);
        ent_t h;
        check({tag, "_count"}, d, 32'(obs[d].size()), 32'(NPIX));
        for (int i = 0; i < obs[d].size() && i < NPIX; i++) begin
            h = obs[d][i];
            check({tag, "_addr"}, d, 32'(h[DW-1:12]), 32'(i));
            check({tag, "_data"}, d, 32'(h[11:0]), 32'(exp_data(fpix[d][i], gain_of(d))));
        end
    endtask

    task automatic rand_pix(int d);
        for (int k = 0; k < NPIX; k++) fpix[d][k] = 12'($urandom_range(0, 4095));
    endtask

    initial begin
        int   t1_pix [8] = '{0, 1, -1, 2047, -2048, 5, -5, 100};
        int   t1_exp [8] = '{0, 1, 1, 2047, 2048, 5, 5, 100};
        int   t2_pix [3] = '{-1000, 1023, 1024};
        int   t2_exp [3] = '{4000, 4092, 4095};
        int   prev;
        int   a;
        ent_t h;

        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; pix_valid[d] = 1'b0; pix_data[d] = '0; wr_ready[d] = 1'b1;
        end
        mreset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_wr_valid", d, 32'(wr_valid[d]), 32'(0));
            check("rst_busy", d, 32'(busy[d]), 32'(0));
            check("rst_frame_done", d, 32'(frame_done[d]), 32'(0));
            check("rst_overflow", d, 32'(overflow[d]), 32'(0));
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic frame, stray pixels while idle, a start mid-stream, pixels during drain.
        for (int k = 0; k < NPIX; k++) fpix[0][k] = 12'(t1_pix[k]);
        pix_valid[0] = 1'b1; pix_data[0] = 12'd77;
        repeat (3) cyc();
        pix_valid[0] = 1'b0;
        check("idle_no_write", 0, 32'(obs[0].size()), 32'(0));
        start[0] = 1'b1;
        cyc();
        start[0] = 1'b0;
        for (int k = 0; k < NPIX; k++) begin
            pix_valid[0] = 1'b1;
            pix_data[0]  = fpix[0][k];
            start[0]     = (k == 4);
            cyc();
            if (k == 0) check("latency_n1", 0, 32'(wr_valid[0]), 32'(0));
            if (k == 1) check("latency_n2", 0, 32'(wr_valid[0]), 32'(1));
        end
        start[0] = 1'b0;
        pix_data[0] = 12'd999;
        repeat (2) cyc();
        pix_valid[0] = 1'b0;
        wait_done(0, 40, 0, 0);
        check_in_order(0, "t1");
        for (int i = 0; i < obs[0].size() && i < NPIX; i++) begin
            h = obs[0][i];
            check("t1_literal", 0, 32'(h[11:0]), 32'(t1_exp[i]));
        end
        check("t1_overflow", 0, 32'(overflow[0]), 32'(0));

        // Gain of 4 with saturation on the deep instance.
        rand_pix(1);
        for (int k = 0; k < 3; k++) fpix[1][k] = 12'(t2_pix[k]);
        wr_ready[1] = 1'b1;
        run_frame(1, 0, 0, 0);
        check_in_order(1, "t2");
        for (int i = 0; i < 3 && i < obs[1].size(); i++) begin
            h = obs[1][i];
            check("t2_literal", 1, 32'(h[11:0]), 32'(t2_exp[i]));
        end

        // Memory stalled for the whole frame on the 4-entry instance.
        rand_pix(0);
        obs[0].delete();
        wr_ready[0] = 1'b0;
        start[0] = 1'b1;
        cyc();
        start[0] = 1'b0;
        for (int k = 0; k < NPIX; k++) begin
            pix_valid[0] = 1'b1;
            pix_data[0]  = fpix[0][k];
            cyc();
        end
        pix_valid[0] = 1'b0;
        repeat (3) cyc();
        check("t3_hold_valid", 0, 32'(wr_valid[0]), 32'(1));
        check("t3_hold_addr", 0, 32'(wr_addr[0]), 32'(0));
        check("t3_overflow", 0, 32'(overflow[0]), 32'(1));
        cyc();
        check("t3_hold_stable", 0, 32'(wr_addr[0]), 32'(0));
        wr_ready[0] = 1'b1;
        wait_done(0, 40, 0, 0);
        check("t3_count", 0, 32'(obs[0].size()), 32'(4));
        for (int i = 0; i < obs[0].size() && i < 4; i++) begin
            h = obs[0][i];
            check("t3_addr", 0, 32'(h[DW-1:12]), 32'(i));
            check("t3_data", 0, 32'(h[11:0]), 32'(exp_data(fpix[0][i], 0)));
        end
        check("t3_overflow_sticky", 0, 32'(overflow[0]), 32'(1));

        // Alternating ready on the 16-entry instance.
        rand_pix(1);
        wr_ready[1] = 1'b1;
        run_frame(1, 1, 0, 0);
        check_in_order(1, "t4");
        check("t4_overflow", 1, 32'(overflow[1]), 32'(0));

        // Asynchronous reset with writes pending, then a clean frame.
        rand_pix(0);
        wr_ready[0] = 1'b0;
        start[0] = 1'b1;
        cyc();
        start[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pix_valid[0] = 1'b1;
            pix_data[0]  = fpix[0][k];
            cyc();
        end
        pix_valid[0] = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("r6_wr_valid", d, 32'(wr_valid[d]), 32'(0));
            check("r6_wr_addr", d, 32'(wr_addr[d]), 32'(0));
            check("r6_wr_data", d, 32'(wr_data[d]), 32'(0));
            check("r6_busy", d, 32'(busy[d]), 32'(0));
            check("r6_frame_done", d, 32'(frame_done[d]), 32'(0));
            check("r6_overflow", d, 32'(overflow[d]), 32'(0));
        end
        mreset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        wr_ready[0] = 1'b1;
        run_frame(0, 0, 0, 0);
        check_in_order(0, "t6");
        check("t6_overflow", 0, 32'(overflow[0]), 32'(0));

        // Randomised frames: gaps in pixels, random memory readiness.
        for (int r = 0; r < 2; r++) begin
            rand_pix(1);
            run_frame(1, 2, 60, 2);
            check_in_order(1, "rand1");
        end
        for (int r = 0; r < 2; r++) begin
            rand_pix(0);
            run_frame(0, 2, 50, 1);
            check("rand0_count_le", 0, 32'(obs[0].size() <= NPIX), 32'(1));
            prev = -1;
            for (int i = 0; i < obs[0].size(); i++) begin
                h = obs[0][i];
                a = int'(h[DW-1:12]);
                check("rand0_order", 0, 32'(a > prev), 32'(1));
                if (a < NPIX) check("rand0_data", 0, 32'(h[11:0]), 32'(exp_data(fpix[0][a], 0)));
                prev = a;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
